// File: rtl/tpu_pkg.sv
// Shared types, sizes and the accumulator saturation helper for the matmul core.
package tpu_pkg;

   localparam int unsigned N      = 2;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned ACC_W  = 2*DATA_W + $clog2(N) + 1;
   localparam int unsigned CNT_W  = $clog2(2*N*N);
   localparam int unsigned K_W    = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      LOAD,
      COMPUTE,
      OUTPUT
   } state_t;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   // Clamp a full-precision accumulator into the signed output word range.
   function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] x);
      if (x > SAT_MAX)      return OUT_W'(SAT_MAX);
      else if (x < SAT_MIN) return OUT_W'(SAT_MIN);
      else                  return OUT_W'(x);
   endfunction

endpackage

// File: rtl/tpu_matmul_core_if.sv
// Byte-stream operand input and handshaked result output of the matmul core.
interface tpu_matmul_core_if;

   logic [tpu_pkg::DATA_W-1:0] in_data;
   logic                       in_valid;
   logic [tpu_pkg::DATA_W-1:0] out_data;
   logic                       out_valid;
   logic                       out_ready;

   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output out_data,
      output out_valid
   );

endinterface

// File: rtl/tpu_mac_row.sv
// One row of C: LANES signed multiply-accumulators sharing the A[i][k] operand.
module tpu_mac_row
   import tpu_pkg::*;
#(
   parameter int unsigned LANES = N
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     step,
   input  logic signed [DATA_W-1:0] a_val,
   input  logic signed [DATA_W-1:0] b_row [LANES],
   output logic signed [ACC_W-1:0]  acc   [LANES]
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < LANES; j++) acc[j] <= '0;
      end else if (clear) begin
         for (int j = 0; j < LANES; j++) acc[j] <= '0;
      end else if (step) begin
         for (int j = 0; j < LANES; j++)
            acc[j] <= acc[j] + ACC_W'(a_val) * ACC_W'(b_row[j]);
      end
   end

endmodule

// File: rtl/tpu_matmul_core.sv
// Loads A and B as a byte stream, computes C = A*B one k-step per cycle,
// then serialises saturated C words low byte first over a valid/ready port.
module tpu_matmul_core
   import tpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 ena,
   tpu_matmul_core_if.slave     bus,
   output logic                 busy
);

   localparam int unsigned LAST_BYTE = 2*N*N - 1;

   state_t                   state;
   logic [CNT_W-1:0]         ld_cnt;
   logic [CNT_W-1:0]         out_idx;
   logic [K_W-1:0]           k_cnt;

   logic signed [DATA_W-1:0] a_mem [N][N];
   logic signed [DATA_W-1:0] b_mem [N][N];
   logic signed [ACC_W-1:0]  c_acc [N][N];

   logic signed [DATA_W-1:0] a_sel_c [N];
   logic signed [DATA_W-1:0] b_sel_c [N];
   logic signed [OUT_W-1:0]  c_sat_c [N*N];
   logic                     clear_c;
   logic                     step_c;
   logic [CNT_W-1:0]         sel_idx_c;
   logic [OUT_W-1:0]         sel_word_c;
   logic [DATA_W-1:0]        next_byte_c;

   assign clear_c = ena && (state == LOAD) && bus.in_valid && (ld_cnt == CNT_W'(LAST_BYTE));
   assign step_c  = ena && (state == COMPUTE);

   // Column k of A and row k of B feed the MAC array this cycle.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_sel_c[i] = a_mem[i][k_cnt];
         b_sel_c[i] = b_mem[k_cnt][i];
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      tpu_mac_row #(.LANES(N)) u_row (
         .clk   (clk),
         .rst_n (rst_n),
         .clear (clear_c),
         .step  (step_c),
         .a_val (a_sel_c[gi]),
         .b_row (b_sel_c),
         .acc   (c_acc[gi])
      );
   end

   // Byte that goes onto out_data at the next load of the output register.
   always_comb begin
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            c_sat_c[i*N+j] = saturate(c_acc[i][j]);
      sel_idx_c   = bus.out_valid ? out_idx + CNT_W'(1) : out_idx;
      sel_word_c  = c_sat_c[sel_idx_c[CNT_W-1:1]];
      next_byte_c = sel_idx_c[0] ? sel_word_c[OUT_W-1:DATA_W] : sel_word_c[DATA_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= LOAD;
         ld_cnt        <= '0;
         out_idx       <= '0;
         k_cnt         <= '0;
         busy          <= 1'b0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               a_mem[i][j] <= '0;
               b_mem[i][j] <= '0;
            end
      end else if (ena) begin
         case (state)
            LOAD: begin
               if (bus.in_valid) begin
                  for (int i = 0; i < N; i++)
                     for (int j = 0; j < N; j++) begin
                        if (ld_cnt == CNT_W'(i*N + j))       a_mem[i][j] <= bus.in_data;
                        if (ld_cnt == CNT_W'(N*N + i*N + j)) b_mem[i][j] <= bus.in_data;
                     end
                  if (ld_cnt == CNT_W'(LAST_BYTE)) begin
                     ld_cnt <= '0;
                     k_cnt  <= '0;
                     state  <= COMPUTE;
                     busy   <= 1'b1;
                  end else begin
                     ld_cnt <= ld_cnt + CNT_W'(1);
                  end
               end
            end
            COMPUTE: begin
               if (k_cnt == K_W'(N-1)) begin
                  k_cnt <= '0;
                  state <= OUTPUT;
               end else begin
                  k_cnt <= k_cnt + K_W'(1);
               end
            end
            OUTPUT: begin
               // First OUTPUT cycle primes the register; afterwards advance per handshake.
               if (!bus.out_valid) begin
                  bus.out_data  <= next_byte_c;
                  bus.out_valid <= 1'b1;
               end else if (bus.out_ready) begin
                  if (out_idx == CNT_W'(LAST_BYTE)) begin
                     bus.out_valid <= 1'b0;
                     out_idx       <= '0;
                     state         <= LOAD;
                     busy          <= 1'b0;
                  end else begin
                     out_idx      <= out_idx + CNT_W'(1);
                     bus.out_data <= next_byte_c;
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_matmul_core.sv
// Directed bench for tpu_matmul_core with hand-computed 2x2 results.
module tb_tpu_matmul_core;

   typedef logic [7:0] vec_t [8];

   logic clk = 1'b0;
   logic rst_n;
   logic ena;
   logic busy;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   t_last;

   tpu_matmul_core_if bus();

   tpu_matmul_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive eight operand bytes; optional idle cycle between bytes.
   task automatic load(input vec_t v, input bit gap);
      for (int i = 0; i < 8; i++) begin
         if (gap && i > 0) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = v[i];
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      t_last = cyc;
   endtask

   // Receive eight result bytes, optionally stalling and injecting stray input bytes.
   task automatic collect(input string job, input vec_t exp, input int lat,
                          input int stall_at, input bit noise);
      int n;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         n = 0;
         @(negedge clk);
         bus.in_valid = noise;
         bus.in_data  = 8'hA5;
         while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!bus.out_valid) begin
            check({job, " out_valid timeout"}, 32'(bus.out_valid), 32'd1);
            bus.in_valid = 1'b0;
            return;
         end
         if (i == 0) begin
            if (lat > 0) check({job, " latency"}, 32'(cyc - t_last), 32'(lat));
            check({job, " busy in output"}, 32'(busy), 32'd1);
         end
         check($sformatf("%s byte%0d", job, i), 32'(bus.out_data), 32'(exp[i]));
         if (i == stall_at) begin
            bus.out_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check($sformatf("%s hold byte%0d", job, i), 32'(bus.out_data), 32'(exp[i]));
               check($sformatf("%s hold valid%0d", job, i), 32'(bus.out_valid), 32'd1);
            end
            bus.out_ready = 1'b1;
         end
         if (i == 7) bus.in_valid = 1'b0;
      end
      @(negedge clk);
      check({job, " valid drops"}, 32'(bus.out_valid), 32'd0);
      check({job, " busy drops"}, 32'(busy), 32'd0);
   endtask

   vec_t v_ident, e_ident, v_mix, e_mix, v_neg, e_neg, v_pos, e_pos, v_new, e_new;

   initial begin
      v_ident = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h00, 8'h00, 8'h01};
      e_ident = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
      v_mix   = '{8'hFF, 8'h02, 8'h03, 8'hFC, 8'h05, 8'h06, 8'h07, 8'h08};
      e_mix   = '{8'h09, 8'h00, 8'h0A, 8'h00, 8'hF3, 8'hFF, 8'hF2, 8'hFF};
      v_neg   = '{default: 8'h80};
      e_neg   = '{8'hFF, 8'h7F, 8'hFF, 8'h7F, 8'hFF, 8'h7F, 8'hFF, 8'h7F};
      v_pos   = '{default: 8'h7F};
      e_pos   = '{8'h02, 8'h7E, 8'h02, 8'h7E, 8'h02, 8'h7E, 8'h02, 8'h7E};
      v_new   = '{8'h02, 8'h00, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04};
      e_new   = '{8'h02, 8'h00, 8'h04, 8'h00, 8'h09, 8'h00, 8'h0C, 8'h00};

      rst_n         = 1'b0;
      ena           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset out_valid", 32'(bus.out_valid), 32'd0);
      check("reset out_data", 32'(bus.out_data), 32'd0);
      rst_n = 1'b1;

      load(v_ident, 1'b0);
      collect("ident", e_ident, 3, -1, 1'b0);

      load(v_mix, 1'b1);
      collect("mix", e_mix, 0, 3, 1'b1);

      // One idle cycle after the previous job, busy must be low.
      check("idle busy", 32'(busy), 32'd0);
      load(v_neg, 1'b0);
      collect("sat_neg", e_neg, 3, -1, 1'b0);

      load(v_pos, 1'b0);
      ena = 1'b0;
      repeat (4) @(negedge clk);
      check("ena frozen valid", 32'(bus.out_valid), 32'd0);
      ena = 1'b1;
      collect("ena", e_pos, 7, -1, 1'b0);

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.in_data  = 8'h7F;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("midload reset busy", 32'(busy), 32'd0);
      check("midload reset valid", 32'(bus.out_valid), 32'd0);
      rst_n = 1'b1;
      load(v_new, 1'b0);
      collect("after_reset", e_new, 3, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
